mask_decomposer: RTL



---
 rtl/mask_decomposer.sv | 113 +++++++++++
 1 files changed

// File: rtl/mask_decomposer.sv
// Splits a mask into its one-hot components, lowest set bit first, one per
// out_valid/out_ready handshake; done pulses once the mask is exhausted.
module mask_decomposer #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             done,
  output logic [IDX_W:0]   pop_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] remaining_reg, remaining_next;
  logic [IDX_W:0]   cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic [IDX_W:0]   pop_count_reg, pop_count_next;

  logic [WIDTH-1:0] lowest;
  logic [WIDTH-1:0] rest;
  logic             is_last;
  logic [IDX_W-1:0] low_index;
  logic [WIDTH-1:0] idx_terms [IDX_W];

  assign lowest  = remaining_reg & (~remaining_reg + 1'b1);
  assign rest    = remaining_reg & ~lowest;
  assign is_last = (rest == '0);

  // Index bit gi is the OR of every one-hot position whose binary index has bit gi set.
  generate
    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_idx_bit
      for (genvar gj = 0; gj < WIDTH; gj++) begin : g_idx_term
        assign idx_terms[gi][gj] = lowest[gj] & (((gj >> gi) % 2) == 1);
      end
      assign low_index[gi] = |idx_terms[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      pop_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      cnt_reg       <= cnt_next;
      done_reg      <= done_next;
      pop_count_reg <= pop_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    cnt_next       = cnt_reg;
    done_next      = 1'b0;
    pop_count_next = pop_count_reg;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_onehot     = '0;
    out_index      = '0;
    out_last       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          remaining_next = in_mask;
          cnt_next       = '0;
          if (in_mask != '0) begin
            state_next = EMIT;
          end else begin
            // An empty mask completes immediately with zero components.
            done_next      = 1'b1;
            pop_count_next = '0;
          end
        end
      end
      EMIT: begin
        out_valid  = 1'b1;
        out_onehot = lowest;
        out_index  = low_index;
        out_last   = is_last;
        if (out_ready) begin
          remaining_next = rest;
          cnt_next       = cnt_reg + 1'b1;
          if (is_last) begin
            state_next     = IDLE;
            done_next      = 1'b1;
            pop_count_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign done      = done_reg;
  assign pop_count = pop_count_reg;

endmodule
